mips_multicycle_control: RTL
============================

# mips_multicycle_control

Main control unit of the multicycle MIPS datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the 3-bit `aluop` consumed by the main ALU and all datapath mux selects and write enables. It also samples the ALU `zero` flag to resolve branches. It reads `opcode`/`funct` from the instruction register and sits beside the datapath; it holds no datapath registers itself.

## Interface
Parameters: none. All encodings are fixed constants.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]. Stable from DECODE until the next FETCH.
- `funct` in 6: IR[5:0]. Same stability as `opcode`.
- `zero` in 1: ALU zero flag. Valid only when `aluop`=110.
- `aluop` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `alusrca` out 1: 0=PC, 1=regA.
- `alusrcb` out 2: 00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `pcsrc` out 2: 00=ALU result, 01=ALUOut register, 10=jump target.
- `pcen` out 1: PC write enable, equal to `pcwrite | (branch & zero)`.
- `iord` out 1: memory address select, 0=PC, 1=ALUOut.
- `memwrite` out 1: data memory write.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: 0=rt, 1=rd.
- `memtoreg` out 1: 0=ALUOut, 1=MDR.
- `regwrite` out 1: register file write.
- `illegal` out 1: single-cycle pulse in DECODE for an unsupported opcode or funct.

## Operation
- Supported opcodes:
  - R-type 000000, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw/sw, EXECUTE for legal R-type, BRANCH for beq, ADDIEXEC for addi, JUMP for j.
  - DECODE→FETCH for anything else, with `illegal`=1. This covers an R-type with unknown funct; no state is written.
  - MEMADR→MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB; EXECUTE→ALUWB; ADDIEXEC→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP→FETCH.
- Outputs per state. Any signal not listed is 0, and `aluop` defaults to 010.
  - FETCH: alusrcb=01, irwrite=1, pcen=1.
  - DECODE: alusrcb=11 (precompute branch target).
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, aluop=decoded from funct.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=110, pcsrc=01, pcen=`zero`.
  - ADDIEXEC: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcen=1.
- `pcen` is the only Mealy output; it is combinational on `zero` in BRANCH only. All other outputs decode from the state register alone.
- Funct decode outside EXECUTE has no effect on `aluop`.

## Timing
- Cycles per instruction, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- State register updates on the rising edge of `clk`. Outputs are valid combinationally within the cycle of their state.
- Reset:
  - While `reset`=1, all enables (pcen, irwrite, memwrite, regwrite) are 0, all selects are 0, `aluop`=010, and `illegal`=0.
  - The state becomes FETCH at the first edge with `reset` high.
  - The first cycle after `reset` falls is FETCH with pcen=1.
- Reset mid-instruction, including in MEMWR or ALUWB: the write enable drops in the same cycle `reset` rises, and no partial write is issued afterwards.
- beq, not-taken (`zero`=0 in BRANCH): pcen=0 for that cycle, and the PC keeps PC+4 from FETCH.
- `zero` changing in any state other than BRANCH must not affect any output.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode and funct localparams;
  - aluop codes (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111);
  - a 4-bit state enum;
  - alusrcb/pcsrc select constants.
- One sub-module, `mips_alu_decoder`: combinational map from `funct` to {aluop, legal}. It is instantiated once; its legal output feeds the DECODE transition.
- Top level: state register, next-state case, output decode case.

## Test plan
- Reset held 3 cycles, then released with opcode=100011 → all enables 0 during reset, then FETCH (irwrite=1, pcen=1, alusrcb=01), then DECODE, MEMADR, MEMRD, then MEMWB with regwrite=1 and memtoreg=1, then FETCH.
- R-type funct=100010 → aluop=110 only in EXECUTE, then ALUWB regwrite=1 with regdst=1; funct=101010 → aluop=111 in EXECUTE.
- beq with `zero`=1 in BRANCH → pcen=1, pcsrc=01. Repeat with `zero`=0 → pcen=0; next state FETCH in both cases.
- sw, then j → MEMWR memwrite=1 with iord=1 for exactly one cycle; JUMP pcen=1 with pcsrc=10; cycle counts are 4 and 3.
- opcode=111111, then R-type funct=000000 → `illegal` pulses 1 cycle in DECODE, next state FETCH, no regwrite/memwrite.
- `reset` asserted during MEMWR and during ALUWB → memwrite/regwrite are 0 in that cycle; FETCH follows release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: encodings shared by the multicycle MIPS control unit
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP
  } state_t;
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps R-type funct to an ALU operation and a legality flag
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] aluop,
  output logic       legal
);
  // unknown funct codes fall back to add and are flagged illegal
  always_comb begin
    aluop = ALU_ADD;
    legal = 1'b1;
    case (funct)
      FN_ADD:  aluop = ALU_ADD;
      FN_SUB:  aluop = ALU_SUB;
      FN_AND:  aluop = ALU_AND;
      FN_OR:   aluop = ALU_OR;
      FN_SLT:  aluop = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore sequencer for the multicycle MIPS datapath
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal
);
  state_t     state, nxt;
  logic [2:0] dec_aluop;
  logic       dec_legal, legal_op, pcwrite, branch;

  mips_alu_decoder u_dec (.funct(funct), .aluop(dec_aluop), .legal(dec_legal));

  assign legal_op = (opcode == OP_RTYPE) ? dec_legal :
                    (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_BEQ) ||
                    (opcode == OP_ADDI) || (opcode == OP_J);
  assign pcen = pcwrite | (branch & zero);

  // state register; reset parks the machine in FETCH
  always_ff @(posedge clk) state <= reset ? S_FETCH : nxt;

  // next-state selection; illegal instructions return straight to FETCH
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:    nxt = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = dec_legal ? S_EXECUTE : S_FETCH;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEXEC;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      S_MEMADR:   nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    nxt = S_MEMWB;
      S_EXECUTE:  nxt = S_ALUWB;
      S_ADDIEXEC: nxt = S_ADDIWB;
      default:    nxt = S_FETCH;
    endcase
  end

  // per-state output decode, forced idle while reset is high so writes drop immediately
  always_comb begin
    aluop    = ALU_ADD;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REGB;
    pcsrc    = PC_ALU;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    illegal  = 1'b0;
    if (!reset)
      case (state)
        S_FETCH: begin
          alusrcb = SRCB_FOUR;
          irwrite = 1'b1;
          pcwrite = 1'b1;
        end
        S_DECODE: begin
          alusrcb = SRCB_IMMSH;
          illegal = !legal_op;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        S_MEMRD:  iord = 1'b1;
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXECUTE: begin
          alusrca = 1'b1;
          aluop   = dec_aluop;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALU_SUB;
          pcsrc   = PC_ALUOUT;
          branch  = 1'b1;
        end
        S_ADDIEXEC: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_JUMP: begin
          pcsrc   = PC_JUMP;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
  end
endmodule
